// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared constants and FSM state encoding for the SPI responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package spi_pkg;

    localparam int SPI_ADDR_W     = 7;
    localparam int SPI_DATA_W     = 8;
    localparam int SPI_FRAME_BITS = 16;
    localparam logic [SPI_ADDR_W-1:0] SPI_FRAME_CNT_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        WAIT_CS = 2'd3
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Two-flop synchroniser plus history flop with rise/fall detect.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Reset to the line's idle level so no false edge fires after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= IDLE_VAL;
            r_sync <= IDLE_VAL;
            r_hist <= IDLE_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

`default_nettype wire

// File: rtl/spi_slave_regs.sv
// ============================================================================
//  Module   : spi_slave_regs
//  Purpose  : SPI responder (RW + 7-bit addr + 8-bit data) over a byte register
//             file with a local port. Option: SPI_SLAVE_FRAME_CNT_EN makes
//             address 7'h7F a read-only completed-frame counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_slave_regs #(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [6:0] loc_addr,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err
);

    import spi_pkg::*;

`ifdef SPI_SLAVE_FRAME_CNT_EN
    localparam logic c_CNT_EN = 1'b1;
`else
    localparam logic c_CNT_EN = 1'b0;
`endif
    localparam logic [7:0] c_DEPTH = 8'(DEPTH);

    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .i_async(sck),
        .o_sync(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(cs),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    assign w_unused = &{1'b0, w_sck_lvl, w_mosi_rise, w_mosi_fall};

    spi_state_t r_state;
    logic [4:0] r_bit_cnt;
    logic [7:0] r_cmd_sr;
    logic [7:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [7:0] r_regs [DEPTH];
    logic [7:0] w_frame_cnt;

    logic [7:0] w_cmd_next;
    logic [7:0] w_rx_byte;
    logic       w_last_rise;
    logic       w_commit;
    logic       w_loc_wr;

    function automatic logic f_writable(input logic [6:0] a);
        return ({1'b0, a} < c_DEPTH) && !(c_CNT_EN && (a == SPI_FRAME_CNT_ADDR));
    endfunction

    function automatic logic [7:0] f_read(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == 7'(i)) v = r_regs[i];
        end
        if (c_CNT_EN && (a == SPI_FRAME_CNT_ADDR)) v = w_frame_cnt;
        return v;
    endfunction

    assign w_cmd_next  = {r_cmd_sr[6:0], w_mosi};
    assign w_rx_byte   = {r_rx_sr[6:0], w_mosi};
    assign w_last_rise = (r_state == DATA) && !w_cs_sync && w_sck_rise &&
                         (r_bit_cnt == 5'(SPI_FRAME_BITS - 1));
    assign w_commit    = w_last_rise && !r_cmd_sr[7] && f_writable(r_cmd_sr[6:0]);
    assign w_loc_wr    = loc_we && f_writable(loc_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_cmd_sr   <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            miso       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_stb     <= w_commit;
            frame_done <= w_last_rise;
            frame_err  <= 1'b0;
            if (w_commit) begin
                wr_addr <= r_cmd_sr[6:0];
                wr_data <= w_rx_byte;
            end
            if (w_cs_sync) begin
                if ((r_state == CMD) || (r_state == DATA)) frame_err <= w_cs_rise;
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                miso      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) r_state <= CMD;
                    end
                    CMD: begin
                        if (w_sck_rise) begin
                            r_cmd_sr  <= w_cmd_next;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            // Read data is frozen here; later writes do not disturb it.
                            if (r_bit_cnt == 5'(SPI_ADDR_W)) begin
                                r_tx_sr <= f_read(w_cmd_next[6:0]);
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (w_sck_fall && r_cmd_sr[7]) begin
                            miso    <= r_tx_sr[7];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end
                        if (w_sck_rise) begin
                            r_rx_sr   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'(SPI_FRAME_BITS - 1)) r_state <= WAIT_CS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // SPI commit is applied after the local write so it wins a same-address collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                r_regs[i] <= RST_VAL;
            end else begin
                if (w_loc_wr && (loc_addr == 7'(i))) r_regs[i] <= loc_wdata;
                if (w_commit && (r_cmd_sr[6:0] == 7'(i))) r_regs[i] <= w_rx_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) loc_rdata <= 8'h00;
        else        loc_rdata <= f_read(loc_addr);
    end

`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n)          r_frame_cnt <= 8'h00;
        else if (frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
    assign w_frame_cnt = r_frame_cnt;
`else
    assign w_frame_cnt = 8'h00;
`endif

endmodule

`default_nettype wire
